raxm_mul_arbiter: RTL

- Round-robin arbiter that shares one pipelined approximate multiplier (operands a, b, level mask l; product p) between NREQ requesters, e.g. the Wishbone register port and the logic-analyser port.
- Accepts one operation per cycle, registers operands toward the multiplier and tags each operation with its requester ID through a LAT-deep tag pipeline.
- Steers each returning product into a per-requester result buffer held until the requester accepts it.
- Sits between the bus/LA front-ends and a single multiplier instance.

---
 rtl/raxm_mul_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/raxm_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between NREQ requesters.
// Optional per-requester grant and stall counters are enabled with RAXM_ARB_PERF_EN.
module raxm_mul_arbiter #(
    parameter int NREQ = 2,
    parameter int W    = 16,
    parameter int LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*W-1:0]     req_a,
    input  logic [NREQ*W-1:0]     req_b,
    input  logic [NREQ*W-1:0]     req_l,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [NREQ*2*W-1:0]   rsp_p,
    output logic [W-1:0]          mul_a,
    output logic [W-1:0]          mul_b,
    output logic [W-1:0]          mul_l,
    input  logic [2*W-1:0]        mul_p,
`ifdef RAXM_ARB_PERF_EN
    input  logic                  perf_clr,
    output logic [NREQ*16-1:0]    perf_grants,
    output logic [15:0]           perf_stall,
`endif
    output logic                  busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [LAT-1:0]   r_tag_v;
    logic [IDW-1:0]   r_tag_id [LAT];
    logic [IDW-1:0]   r_ptr;
    logic [NREQ-1:0]  r_rsp_v;
    logic [2*W-1:0]   r_rsp_p [NREQ];
    logic [W-1:0]     r_mul_a;
    logic [W-1:0]     r_mul_b;
    logic [W-1:0]     r_mul_l;

    logic [NREQ-1:0]  w_inflight;
    logic [NREQ-1:0]  w_elig;
    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_gid;
    logic             w_issue;
    int               w_idx;

    // Eligibility from registered state only: one outstanding op per requester.
    always_comb begin
        w_inflight = '0;
        for (int s = 0; s < LAT; s++) begin
            w_inflight[r_tag_id[s]] = w_inflight[r_tag_id[s]] | r_tag_v[s];
        end
        w_elig = req_valid & ~w_inflight & ~r_rsp_v & {NREQ{~rst}};
    end

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        w_grant = '0;
        w_issue = 1'b0;
        w_gid   = '0;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx          = (int'(r_ptr) + k) % NREQ;
            w_grant[w_idx] = w_elig[w_idx] & ~w_issue;
            w_issue        = w_issue | w_elig[w_idx];
        end
        for (int i = 0; i < NREQ; i++) begin
            w_gid = w_gid | (w_grant[i] ? IDW'(i) : {IDW{1'b0}});
        end
    end

    // Operand registers toward the multiplier and the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_a <= {W{1'b0}};
            r_mul_b <= {W{1'b0}};
            r_mul_l <= {W{1'b0}};
            r_ptr   <= IDW'(NREQ - 1);
        end else if (w_issue) begin
            r_mul_a <= req_a[int'(w_gid)*W +: W];
            r_mul_b <= req_b[int'(w_gid)*W +: W];
            r_mul_l <= req_l[int'(w_gid)*W +: W];
            r_ptr   <= w_gid;
        end
    end

    // Tag pipeline: stage LAT-1 pairs mul_p with its requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_v <= '0;
            for (int s = 0; s < LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            r_tag_v[0]  <= w_issue;
            r_tag_id[0] <= w_gid;
            for (int s = 1; s < LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    // Result buffers: consume clears valid, capture loads product for the tagged id.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_v <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_rsp_p[i] <= {(2*W){1'b0}};
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (r_rsp_v[i] && rsp_ready[i]) begin
                    r_rsp_v[i] <= 1'b0;
                end
            end
            if (r_tag_v[LAT-1]) begin
                r_rsp_v[r_tag_id[LAT-1]] <= 1'b1;
                r_rsp_p[r_tag_id[LAT-1]] <= mul_p;
            end
        end
    end

    // Pack per-requester result buffers onto the flat output bus.
    always_comb begin
        rsp_p = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_p[i*2*W +: 2*W] = r_rsp_p[i];
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_v;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_l     = r_mul_l;
    assign busy      = (|r_tag_v) | (|r_rsp_v);

`ifdef RAXM_ARB_PERF_EN
    logic [15:0] r_perf_g [NREQ];
    logic [15:0] r_perf_stall;

    // Saturating grant and stall counters with synchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall <= 16'd0;
            for (int i = 0; i < NREQ; i++) begin
                r_perf_g[i] <= 16'd0;
            end
        end else if (perf_clr) begin
            r_perf_stall <= 16'd0;
            for (int i = 0; i < NREQ; i++) begin
                r_perf_g[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_grant[i] && (r_perf_g[i] != 16'hFFFF)) begin
                    r_perf_g[i] <= r_perf_g[i] + 16'd1;
                end
            end
            if ((|req_valid) && !w_issue && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
        end
    end

    // Pack grant counters onto the flat output bus.
    always_comb begin
        perf_grants = '0;
        for (int i = 0; i < NREQ; i++) begin
            perf_grants[i*16 +: 16] = r_perf_g[i];
        end
    end

    assign perf_stall = r_perf_stall;
`endif

endmodule
